// File: rtl/fma_arbiter_if.sv
// Bundle of requester, fused-unit and response signals around fma_arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface fma_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [63:0] req_c;
  logic [3:0]  req_op;
  logic [5:0]  req_rm;
  logic [2:0]  frm;

  logic        fma_start;
  logic [31:0] fma_a;
  logic [31:0] fma_b;
  logic [31:0] fma_c;
  logic        fma_is_sub;
  logic        fma_is_neg;
  logic [2:0]  fma_rm;
  logic [31:0] fma_result;
  logic [3:0]  fma_flags;
  logic        fma_done;

  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_fflags;
  logic        rsp_illegal;
  logic        rsp_timeout;

  logic [4:0]  acc_fflags;
  logic        fflags_clr;
  logic        busy;

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_op, req_rm, frm,
           fma_result, fma_flags, fma_done, rsp_ready, fflags_clr,
    output req_ready, fma_start, fma_a, fma_b, fma_c, fma_is_sub, fma_is_neg,
           fma_rm, rsp_valid, rsp_result, rsp_fflags, rsp_illegal, rsp_timeout,
           acc_fflags, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_c, req_op, req_rm, frm,
           fma_result, fma_flags, fma_done, rsp_ready, fflags_clr,
    input  req_ready, fma_start, fma_a, fma_b, fma_c, fma_is_sub, fma_is_neg,
           fma_rm, rsp_valid, rsp_result, rsp_fflags, rsp_illegal, rsp_timeout,
           acc_fflags, busy
  );
endinterface

// File: rtl/fma_arbiter.sv
// Round-robin front end sharing one fused multiply-add unit between two requesters,
// with rounding-mode legality check, completion timeout and sticky accrued flags.
module fma_arbiter #(
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  fma_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_lastGrant;
  logic          r_owner;
  logic [CW-1:0] r_count;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_c;
  logic          r_isSub;
  logic          r_isNeg;
  logic [2:0]    r_rm;
  logic [31:0]   r_rspResult;
  logic [4:0]    r_rspFflags;
  logic          r_rspIllegal;
  logic          r_rspTimeout;
  logic [4:0]    r_accFflags;

  logic          w_grant;
  logic          w_accept;
  logic          w_illegal;
  logic          w_countHit;
  logic          w_handshake;
  logic [2:0]    w_reqRm;
  logic [2:0]    w_rm;
  logic [1:0]    w_reqOp;

  // On a tie the requester that did not win last time gets the unit.
  always_comb begin
    w_grant = bus.req_valid[1];
    if (&bus.req_valid) w_grant = ~r_lastGrant;
    w_reqRm    = w_grant ? bus.req_rm[5:3] : bus.req_rm[2:0];
    w_reqOp    = w_grant ? bus.req_op[3:2] : bus.req_op[1:0];
    w_rm       = (w_reqRm == 3'b111) ? bus.frm : w_reqRm;
    w_illegal  = (w_rm == 3'b101) || (w_rm == 3'b110) || (w_rm == 3'b111);
    w_accept   = (r_state == IDLE) && (|bus.req_valid) && !rst;
    w_countHit = (r_count == CW'(TIMEOUT - 1));
    w_handshake = (r_state == RESP) && bus.rsp_ready[r_owner];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    bus.req_ready = 2'b00;
    bus.fma_start = 1'b0;
    bus.rsp_valid = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          bus.req_ready = w_grant ? 2'b10 : 2'b01;
          w_nextState   = w_illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        bus.fma_start = 1'b1;
        w_nextState   = WAIT;
      end
      WAIT: begin
        if (bus.fma_done || w_countHit) w_nextState = RESP;
      end
      RESP: begin
        bus.rsp_valid = r_owner ? 2'b10 : 2'b01;
        if (bus.rsp_ready[r_owner]) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A done coinciding with the final count takes the normal-completion branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastGrant  <= 1'b1;
      r_owner      <= 1'b0;
      r_count      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_isSub      <= 1'b0;
      r_isNeg      <= 1'b0;
      r_rm         <= '0;
      r_rspResult  <= '0;
      r_rspFflags  <= '0;
      r_rspIllegal <= 1'b0;
      r_rspTimeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lastGrant <= w_grant;
            r_owner     <= w_grant;
            r_a         <= w_grant ? bus.req_a[63:32] : bus.req_a[31:0];
            r_b         <= w_grant ? bus.req_b[63:32] : bus.req_b[31:0];
            r_c         <= w_grant ? bus.req_c[63:32] : bus.req_c[31:0];
            r_isSub     <= w_reqOp[0];
            r_isNeg     <= w_reqOp[1];
            r_rm        <= w_rm;
            if (w_illegal) begin
              r_rspResult  <= '0;
              r_rspFflags  <= '0;
              r_rspIllegal <= 1'b1;
              r_rspTimeout <= 1'b0;
            end
          end
        end
        ISSUE: r_count <= '0;
        WAIT: begin
          if (bus.fma_done) begin
            r_rspResult  <= bus.fma_result;
            r_rspFflags  <= {bus.fma_flags[3], 1'b0, bus.fma_flags[2:0]};
            r_rspIllegal <= 1'b0;
            r_rspTimeout <= 1'b0;
          end else if (w_countHit) begin
            r_rspResult  <= 32'h7FC0_0000;
            r_rspFflags  <= 5'b10000;
            r_rspIllegal <= 1'b0;
            r_rspTimeout <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A clear landing on a handshake keeps only the flags of that response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accFflags <= '0;
    end else if (bus.fflags_clr) begin
      r_accFflags <= w_handshake ? r_rspFflags : 5'b00000;
    end else if (w_handshake) begin
      r_accFflags <= r_accFflags | r_rspFflags;
    end
  end

  assign bus.fma_a       = r_a;
  assign bus.fma_b       = r_b;
  assign bus.fma_c       = r_c;
  assign bus.fma_is_sub  = r_isSub;
  assign bus.fma_is_neg  = r_isNeg;
  assign bus.fma_rm      = r_rm;
  assign bus.rsp_result  = r_rspResult;
  assign bus.rsp_fflags  = r_rspFflags;
  assign bus.rsp_illegal = r_rspIllegal;
  assign bus.rsp_timeout = r_rspTimeout;
  assign bus.acc_fflags  = r_accFflags;
  assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fma_arbiter.sv
// Directed and randomized transactions against fma_arbiter, checked by a
// transaction-level model of grant order, response payload and accrued flags.
module tb_fma_arbiter;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;

  fma_arbiter_if bus ();

  fma_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] reqA [2];
  logic [31:0] reqB [2];
  logic [31:0] reqC [2];
  logic [1:0]  reqOp [2];
  logic [2:0]  reqRm [2];

  int         mLastGrant;
  logic [4:0] mAcc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {is_sub, is_neg} for each operation code.
  function automatic logic [1:0] expSubNeg(input logic [1:0] op);
    case (op)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  task automatic driveRequests(input logic [1:0] valids);
    bus.req_valid = valids;
    bus.req_a     = {reqA[1], reqA[0]};
    bus.req_b     = {reqB[1], reqB[0]};
    bus.req_c     = {reqC[1], reqC[0]};
    bus.req_op    = {reqOp[1], reqOp[0]};
    bus.req_rm    = {reqRm[1], reqRm[0]};
  endtask

  // One full transaction from IDLE through the response handshake.
  // lat < 0 means the unit never answers.
  task automatic applyStimulus(input logic [1:0] valids, input int lat,
                               input logic [31:0] uRes, input logic [3:0] uFlags,
                               input bit clrAtHs, input bit spurious);
    int          g;
    logic [2:0]  r;
    bit          ill;
    logic [31:0] expRes;
    logic [4:0]  expF;
    bit          expTo;
    logic [1:0]  sn;

    driveRequests(valids);
    #1;
    if (valids == 2'b11) g = (mLastGrant == 0) ? 1 : 0;
    else                 g = valids[0] ? 0 : 1;
    r   = (reqRm[g] == 3'd7) ? bus.frm : reqRm[g];
    ill = (r >= 3'd5);
    checkOutput("req_ready", bus.req_ready, 2'b01 << g);
    checkOutput("busy_idle", bus.busy, 0);
    tick;
    mLastGrant    = g;
    bus.req_valid = 2'b00;

    if (ill) begin
      expRes = 32'h0;
      expF   = 5'b0;
      expTo  = 1'b0;
      checkOutput("no_start_illegal", bus.fma_start, 0);
    end else begin
      sn = expSubNeg(reqOp[g]);
      checkOutput("fma_start", bus.fma_start, 1);
      checkOutput("fma_a", bus.fma_a, reqA[g]);
      checkOutput("fma_b", bus.fma_b, reqB[g]);
      checkOutput("fma_c", bus.fma_c, reqC[g]);
      checkOutput("fma_is_sub", bus.fma_is_sub, sn[1]);
      checkOutput("fma_is_neg", bus.fma_is_neg, sn[0]);
      checkOutput("fma_rm", bus.fma_rm, r);
      if (spurious) begin
        bus.fma_done   = 1'b1;
        bus.fma_result = 32'hDEAD_BEEF;
      end
      tick;
      bus.fma_done = 1'b0;
      if (lat >= 0) begin
        for (int k = 0; k < lat; k++) begin
          checkOutput("wait_no_rsp", bus.rsp_valid, 0);
          checkOutput("wait_no_start", bus.fma_start, 0);
          tick;
        end
        checkOutput("hold_a", bus.fma_a, reqA[g]);
        checkOutput("hold_rm", bus.fma_rm, r);
        bus.fma_done   = 1'b1;
        bus.fma_result = uRes;
        bus.fma_flags  = uFlags;
        tick;
        bus.fma_done = 1'b0;
        expRes = uRes;
        expF   = {uFlags[3], 1'b0, uFlags[2:0]};
        expTo  = 1'b0;
      end else begin
        for (int k = 0; k < TIMEOUT; k++) begin
          checkOutput("wait_no_rsp", bus.rsp_valid, 0);
          tick;
        end
        expRes = 32'h7FC0_0000;
        expF   = 5'b10000;
        expTo  = 1'b1;
      end
    end

    checkOutput("rsp_valid", bus.rsp_valid, 2'b01 << g);
    checkOutput("rsp_result", bus.rsp_result, expRes);
    checkOutput("rsp_fflags", bus.rsp_fflags, expF);
    checkOutput("rsp_illegal", bus.rsp_illegal, ill);
    checkOutput("rsp_timeout", bus.rsp_timeout, expTo);
    checkOutput("busy_resp", bus.busy, 1);

    // Non-owner ready, fresh requests and a stray done must all be ignored here.
    bus.rsp_ready = 2'b01 << (1 - g);
    bus.req_valid = 2'b11;
    if (spurious) begin
      bus.fma_done   = 1'b1;
      bus.fma_result = 32'h1234_5678;
      bus.fma_flags  = 4'hF;
    end
    #1;
    checkOutput("req_ready_resp", bus.req_ready, 0);
    tick;
    bus.fma_done  = 1'b0;
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b00;
    checkOutput("rsp_hold_valid", bus.rsp_valid, 2'b01 << g);
    checkOutput("rsp_hold_result", bus.rsp_result, expRes);
    checkOutput("rsp_hold_fflags", bus.rsp_fflags, expF);

    bus.rsp_ready  = 2'b01 << g;
    bus.fflags_clr = clrAtHs;
    tick;
    bus.rsp_ready  = 2'b00;
    bus.fflags_clr = 1'b0;
    mAcc = clrAtHs ? expF : (mAcc | expF);
    checkOutput("rsp_dropped", bus.rsp_valid, 0);
    checkOutput("busy_after", bus.busy, 0);
    checkOutput("acc_fflags", bus.acc_fflags, mAcc);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_fma_start"}, bus.fma_start, 0);
    checkOutput({tag, "_req_ready"}, bus.req_ready, 0);
    checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    checkOutput({tag, "_rsp_result"}, bus.rsp_result, 0);
    checkOutput({tag, "_rsp_fflags"}, bus.rsp_fflags, 0);
    checkOutput({tag, "_rsp_illegal"}, bus.rsp_illegal, 0);
    checkOutput({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
    checkOutput({tag, "_acc_fflags"}, bus.acc_fflags, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_fma_a"}, bus.fma_a, 0);
    checkOutput({tag, "_fma_b"}, bus.fma_b, 0);
    checkOutput({tag, "_fma_c"}, bus.fma_c, 0);
    checkOutput({tag, "_is_sub"}, bus.fma_is_sub, 0);
    checkOutput({tag, "_is_neg"}, bus.fma_is_neg, 0);
    checkOutput({tag, "_fma_rm"}, bus.fma_rm, 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_c      = '0;
    bus.req_op     = '0;
    bus.req_rm     = '0;
    bus.frm        = 3'b000;
    bus.fma_result = '0;
    bus.fma_flags  = '0;
    bus.fma_done   = 1'b0;
    bus.rsp_ready  = 2'b00;
    bus.fflags_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      reqA[i] = '0; reqB[i] = '0; reqC[i] = '0; reqOp[i] = '0; reqRm[i] = '0;
    end
    mLastGrant = 1;
    mAcc       = 5'b0;

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick;

    $display("[TB] tie-break after reset, then again");
    reqA[0] = 32'h3F80_0000; reqB[0] = 32'h4000_0000; reqC[0] = 32'h4040_0000;
    reqOp[0] = 2'd1; reqRm[0] = 3'd1;
    reqA[1] = 32'h4080_0000; reqB[1] = 32'h40A0_0000; reqC[1] = 32'h40C0_0000;
    reqOp[1] = 2'd3; reqRm[1] = 3'd2;
    applyStimulus(2'b11, 1, 32'h4110_0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(2'b11, 1, 32'hC120_0000, 4'b0000, 1'b0, 1'b0);

    $display("[TB] requester 0 fmadd 1*2+1");
    reqA[0] = 32'h3F80_0000; reqB[0] = 32'h4000_0000; reqC[0] = 32'h3F80_0000;
    reqOp[0] = 2'd0; reqRm[0] = 3'd0;
    applyStimulus(2'b01, 2, 32'h4040_0000, 4'b0000, 1'b0, 1'b0);

    $display("[TB] requester 1 dynamic rounding with illegal frm");
    reqRm[1] = 3'd7;
    bus.frm  = 3'b101;
    applyStimulus(2'b10, 0, 32'h0, 4'b0000, 1'b0, 1'b0);
    bus.frm  = 3'b000;

    $display("[TB] timeout with no done");
    reqRm[1] = 3'd0;
    applyStimulus(2'b10, -1, 32'h0, 4'b0000, 1'b0, 1'b0);

    $display("[TB] clear coinciding with handshake, then clear alone");
    applyStimulus(2'b01, 3, 32'h3EAA_AAAB, 4'b0001, 1'b1, 1'b0);
    bus.fflags_clr = 1'b1;
    tick;
    bus.fflags_clr = 1'b0;
    mAcc = 5'b0;
    checkOutput("acc_after_clr", bus.acc_fflags, mAcc);

    $display("[TB] done on the final timeout cycle");
    applyStimulus(2'b01, TIMEOUT - 1, 32'h4240_0000, 4'b1010, 1'b0, 1'b0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 24; n++) begin
      logic [1:0] valids;
      int         lat;
      for (int i = 0; i < 2; i++) begin
        reqA[i]  = $urandom;
        reqB[i]  = $urandom;
        reqC[i]  = $urandom;
        reqOp[i] = 2'($urandom_range(0, 3));
        reqRm[i] = 3'($urandom_range(0, 7));
      end
      bus.frm = 3'($urandom_range(0, 7));
      valids  = 2'($urandom_range(1, 3));
      lat     = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
      applyStimulus(valids, lat, $urandom, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset while waiting on the unit");
    bus.frm = 3'b000;
    reqRm[0] = 3'd0;
    applyStimulus(2'b01, -1, 32'h0, 4'b0000, 1'b0, 1'b0);
    reqA[0] = 32'h4100_0000; reqB[0] = 32'h4110_0000; reqC[0] = 32'h4120_0000;
    reqOp[0] = 2'd3; reqRm[0] = 3'd4;
    driveRequests(2'b01);
    tick;
    bus.req_valid = 2'b00;
    tick;
    tick;
    checkOutput("busy_before_rst", bus.busy, 1);
    checkOutput("acc_before_rst", bus.acc_fflags, mAcc);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst        = 1'b0;
    mLastGrant = 1;
    mAcc       = 5'b0;
    tick;
    bus.fma_done   = 1'b1;
    bus.fma_result = 32'hCAFE_F00D;
    bus.fma_flags  = 4'hF;
    tick;
    bus.fma_done = 1'b0;
    checkOutput("late_done_rsp_valid", bus.rsp_valid, 0);
    checkOutput("late_done_busy", bus.busy, 0);
    checkOutput("late_done_result", bus.rsp_result, 0);
    checkOutput("late_done_acc", bus.acc_fflags, 0);
    tick;
    applyStimulus(2'b11, 2, 32'h4480_0000, 4'b0100, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
